// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and the control unit.
package cpu_fetch_pkg;

  typedef enum logic [2:0] {
    OP_ADDR,
    OP_DATA,
    LO_ADDR,
    LO_DATA,
    HI_ADDR,
    HI_DATA,
    HOLD
  } fetch_state_t;

  // Opcode bits that encode the instruction length
  localparam int LEN_FIELD_MSB = 7;
  localparam int LEN_FIELD_LSB = 6;

  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

endpackage

// File: rtl/instr_length_decode.sv
// Maps an opcode to its instruction length in bytes; purely combinational so the
// control unit can reuse it.
module instr_length_decode
  import cpu_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] opcode,
  output logic [1:0]            instr_len
);

  // Only the length field matters; the rest of the opcode is the control unit's business.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode;

  always_comb begin
    case (opcode[LEN_FIELD_MSB:LEN_FIELD_LSB])
      2'b00:   instr_len = LEN1;
      2'b01:   instr_len = LEN2;
      default: instr_len = LEN3;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads 1-3 bytes at the PC, assembles opcode/operand and hands the
// instruction to the control unit over a valid/ready handshake.
module instruction_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   pc_addr,
  output logic                    pc_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    flush,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_WIDTH-1:0]   opcode,
  output logic [2*DATA_WIDTH-1:0] operand,
  output logic [1:0]              instr_len
);

  fetch_state_t            state_q,   state_d;
  logic [DATA_WIDTH-1:0]   opcode_q,  opcode_d;
  logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
  logic [1:0]              len_q,     len_d;

  logic [DATA_WIDTH-1:0]   dec_opcode;
  logic [1:0]              dec_len;
  logic                    addr_phase;

  // In OP_DATA the opcode is still on the bus, so decode it before it is captured.
  assign dec_opcode = (state_q == OP_DATA) ? mem_rdata : opcode_q;

  instr_length_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_length_decode (
    .opcode   (dec_opcode),
    .instr_len(dec_len)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OP_ADDR;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OP_ADDR;
    end else begin
      case (state_q)
        OP_ADDR: state_d = OP_DATA;
        OP_DATA: state_d = (dec_len == LEN1) ? HOLD : LO_ADDR;
        LO_ADDR: state_d = LO_DATA;
        LO_DATA: state_d = (len_q == LEN2) ? HOLD : HI_ADDR;
        HI_ADDR: state_d = HI_DATA;
        HI_DATA: state_d = HOLD;
        HOLD:    if (instr_ready) state_d = OP_ADDR;
        default: state_d = OP_ADDR;
      endcase
    end
  end

  always_comb begin
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    if (flush) begin
      opcode_d  = '0;
      operand_d = '0;
      len_d     = '0;
    end else begin
      case (state_q)
        OP_DATA: begin
          opcode_d  = mem_rdata;
          operand_d = '0;
          len_d     = dec_len;
        end
        LO_DATA: operand_d[DATA_WIDTH-1:0]            = mem_rdata;
        HI_DATA: operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_rdata;
        default: ;
      endcase
    end
  end

  // Read strobe and PC increment are one and the same event: one per byte fetched.
  always_comb begin
    addr_phase  = (state_q == OP_ADDR) || (state_q == LO_ADDR) || (state_q == HI_ADDR);
    mem_rd      = addr_phase && !flush && reset_n;
    pc_enable   = addr_phase && !flush && reset_n;
    mem_addr    = pc_addr;
    instr_valid = (state_q == HOLD);
  end

  assign opcode    = opcode_q;
  assign operand   = operand_q;
  assign instr_len = len_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: RAM + PC environment, and an expected
// instruction stream computed directly from memory contents.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc_addr;
  logic        pc_enable;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;

  instruction_fetch #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_addr    (pc_addr),
    .pc_enable  (pc_enable),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode     (opcode),
    .operand    (operand),
    .instr_len  (instr_len)
  );

  always #5 clk = ~clk;

  // Environment: program counter and synchronous RAM
  logic [7:0]  ram [0:65535];
  logic [15:0] pc;
  logic [15:0] rst_pc = 16'h0000;
  logic [15:0] flush_pc = 16'h0000;

  assign pc_addr = pc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       pc <= rst_pc;
    else if (flush)     pc <= flush_pc;
    else if (pc_enable) pc <= pc + 16'd1;
  end

  // Garbage on the bus when no read is pending: the DUT must ignore it.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opr;
    int          len;
  } instr_t;

  instr_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     pc_en_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk memory from addr and decode n instructions by the length rule.
  task automatic expect_prog(input logic [15:0] addr, input int n);
    logic [15:0] a;
    logic [15:0] a1;
    logic [15:0] a2;
    instr_t      e;
    a = addr;
    for (int k = 0; k < n; k++) begin
      a1 = a + 16'd1;
      a2 = a + 16'd2;
      e.op  = ram[a];
      e.len = (e.op[7:6] == 2'b00) ? 1 : (e.op[7:6] == 2'b01) ? 2 : 3;
      e.opr = {(e.len == 3) ? ram[a2] : 8'h00, (e.len >= 2) ? ram[a1] : 8'h00};
      exp_q.push_back(e);
      a = a + 16'(e.len);
    end
  endtask

  task automatic observe();
    instr_t e;
    if (mem_rd) check("mem_addr", 32'(mem_addr), 32'(pc_addr));
    check("pc_en_eq_rd", 32'(pc_enable), 32'(mem_rd));
    if (pc_enable) pc_en_cnt++;
    if (instr_valid && instr_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("spurious_xfer", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        $display("XFER op=%02h operand=%04h len=%0d", opcode, operand, instr_len);
        check("opcode", 32'(opcode), 32'(e.op));
        check("operand", 32'(operand), 32'(e.opr));
        check("instr_len", 32'(instr_len), 32'(e.len));
      end
    end
  endtask

  task automatic run_cycle();
    #1;
    observe();
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in OP_ADDR; returns at the negedge of the next OP_ADDR.
  task automatic fetch(input int stall);
    int     len;
    int     lat;
    int     pce0;
    instr_t e;
    len  = (exp_q.size() > 0) ? exp_q[0].len : 1;
    e    = exp_q[0];
    pce0 = pc_en_cnt;
    lat  = 0;
    instr_ready = (stall == 0);
    #1;
    check("issue_rd", 32'(mem_rd), 1);
    forever begin
      observe();
      if (instr_valid || lat >= 12) break;
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(2 * len));
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      #1;
      observe();
      check("hold_valid", 32'(instr_valid), 1);
      check("hold_op", 32'(opcode), 32'(e.op));
      check("hold_opr", 32'(operand), 32'(e.opr));
      check("hold_quiet", 32'({mem_rd, pc_enable}), 0);
    end
    if (stall > 0) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      observe();
    end
    check("pc_en_per_instr", 32'(pc_en_cnt - pce0), 32'(len));
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] addr);
    rst_pc      = addr;
    flush       = 1'b0;
    instr_ready = 1'b0;
    exp_q.delete();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Flush a 3-byte fetch at cycle `at` (0 = OP_ADDR) and resume at 0x0100.
  task automatic flush_test(input int at);
    ram[16'h0000] = 8'h83; ram[16'h0001] = 8'h34; ram[16'h0002] = 8'h12;
    ram[16'h0100] = 8'h05;
    do_reset(16'h0000);
    instr_ready = 1'b1;
    for (int i = 0; i < at; i++) run_cycle();
    flush    = 1'b1;
    flush_pc = 16'h0100;
    #1;
    check("flush_rd", 32'(mem_rd), 0);
    check("flush_pc_en", 32'(pc_enable), 0);
    observe();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post_flush_valid", 32'(instr_valid), 0);
    check("post_flush_op", 32'(opcode), 0);
    check("post_flush_opr", 32'(operand), 0);
    check("post_flush_len", 32'(instr_len), 0);
    check("post_flush_addr", 32'(mem_addr), 32'h0100);
    expect_prog(16'h0100, 1);
    fetch(0);
    check("flush_q_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int pce0;
    int lens;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    // Reset values while reset_n is low
    rst_pc = 16'h0000;
    @(negedge clk);
    #1;
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_rd", 32'(mem_rd), 0);
    check("rst_pc_en", 32'(pc_enable), 0);
    check("rst_op", 32'(opcode), 0);
    check("rst_opr", 32'(operand), 0);
    check("rst_len", 32'(instr_len), 0);

    // Single-byte instruction
    ram[16'h0000] = 8'h05;
    do_reset(16'h0000);
    expect_prog(16'h0000, 1);
    fetch(0);

    // Three-byte instruction
    ram[16'h0000] = 8'h83; ram[16'h0001] = 8'h34; ram[16'h0002] = 8'h12;
    do_reset(16'h0000);
    expect_prog(16'h0000, 1);
    fetch(0);

    // Two-byte instruction with the consumer stalling
    ram[16'h0000] = 8'h41; ram[16'h0001] = 8'hAA;
    do_reset(16'h0000);
    expect_prog(16'h0000, 1);
    fetch(5);
    #1;
    check("next_issue_addr", 32'(mem_addr), 2);
    check("next_issue_rd", 32'(mem_rd), 1);

    // Flush in LO_DATA, LO_ADDR and HOLD (with instr_ready high)
    flush_test(3);
    flush_test(2);
    flush_test(6);

    // Asynchronous reset between edges while in HI_ADDR
    ram[16'h0000] = 8'h83; ram[16'h0001] = 8'h34; ram[16'h0002] = 8'h12;
    ram[16'h0020] = 8'h05;
    do_reset(16'h0000);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle();
    #1;
    check("hi_addr_rd", 32'(mem_rd), 1);
    check("hi_addr_op", 32'(opcode), 32'h83);
    rst_pc = 16'h0020;
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rd", 32'(mem_rd), 0);
    check("async_pc_en", 32'(pc_enable), 0);
    check("async_valid", 32'(instr_valid), 0);
    check("async_op", 32'(opcode), 0);
    check("async_opr", 32'(operand), 0);
    check("async_len", 32'(instr_len), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_rd", 32'(mem_rd), 1);
    check("release_addr", 32'(mem_addr), 32'h0020);
    expect_prog(16'h0020, 1);
    fetch(0);

    // Back-to-back 1/2/3-byte stream
    ram[16'h0200] = 8'h05; ram[16'h0201] = 8'h41; ram[16'h0202] = 8'hAA;
    ram[16'h0203] = 8'h83; ram[16'h0204] = 8'h34; ram[16'h0205] = 8'h12;
    do_reset(16'h0200);
    expect_prog(16'h0200, 3);
    pce0 = pc_en_cnt;
    for (int i = 0; i < 3; i++) fetch(0);
    check("stream_pc_en", 32'(pc_en_cnt - pce0), 6);

    // Random programs with random stalls, one crossing the address wrap
    for (int r = 0; r < 2; r++) begin
      do_reset((r == 0) ? 16'h1000 : 16'hFFF0);
      expect_prog(pc, 0);
      expect_prog((r == 0) ? 16'h1000 : 16'hFFF0, 20);
      lens = 0;
      foreach (exp_q[k]) lens += exp_q[k].len;
      pce0 = pc_en_cnt;
      for (int i = 0; i < 20; i++) fetch(int'($urandom_range(0, 3)));
      check("rand_pc_en", 32'(pc_en_cnt - pce0), 32'(lens));
      check("rand_q_empty", 32'(exp_q.size()), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage between the program counter and the control unit. Reads 1-3 instruction bytes from synchronous RAM at the PC address, pulses the PC increment once per byte, and assembles opcode plus operand. The result is presented to the control unit over a valid/ready handshake. A flush input discards in-flight work when the control unit loads the PC (jump/call/return).

Parameters:
ADDR_WIDTH, 16, width of PC/memory address
DATA_WIDTH, 8, width of memory word and opcode

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
pc_addr  input  ADDR_WIDTH  current program counter value
pc_enable  output  1  one-cycle PC increment request
mem_addr  output  ADDR_WIDTH  memory read address
mem_rd  output  1  memory read strobe
mem_rdata  input  DATA_WIDTH  read data, valid one cycle after mem_rd
flush  input  1  discard current fetch; PC is loaded on this same edge
instr_valid  output  1  opcode/operand/instr_len hold a complete instruction
instr_ready  input  1  control unit accepts instruction
opcode  output  DATA_WIDTH  fetched opcode
operand  output  2*DATA_WIDTH  {hi, lo}; unused bytes read as zero
instr_len  output  2  instruction length in bytes (1-3)

Behaviour:
- Reset (reset_n low, async):
  - state = OP_ADDR; opcode, operand, instr_len = 0.
  - instr_valid, mem_rd, pc_enable = 0 while reset_n is low.
- States: OP_ADDR, OP_DATA, LO_ADDR, LO_DATA, HI_ADDR, HI_DATA, HOLD.
- *_ADDR states (combinational outputs):
  - mem_addr = pc_addr; mem_rd = 1; pc_enable = 1, unless flush.
  - Next state is the matching *_DATA state.
- OP_DATA:
  - Capture mem_rdata into opcode; clear operand; set instr_len from the length decode.
  - len 1 -> HOLD; otherwise -> LO_ADDR.
- LO_DATA: capture operand[DATA_WIDTH-1:0]. len 2 -> HOLD; len 3 -> HI_ADDR.
- HI_DATA: capture operand upper byte -> HOLD.
- HOLD:
  - instr_valid = 1 (registered state decode); outputs stable until accepted.
  - instr_valid && instr_ready -> OP_ADDR. Otherwise stay in HOLD.
  - No mem_rd or pc_enable is issued in HOLD.
- Length decode (combinational on opcode[7:6]): 00 -> 1; 01 -> 2; 10 and 11 -> 3.
- Latency from entering OP_ADDR to instr_valid: 2 cycles (len 1), 4 (len 2), 6 (len 3). Accept-to-next-issue: 1 cycle.
- Exactly one pc_enable pulse per byte fetched; the PC is never advanced while in HOLD.
- Flush (synchronous, highest priority, any state):
  - Next state = OP_ADDR. instr_valid = 0 from the next cycle.
  - Captured bytes are discarded; opcode, operand and instr_len are zeroed.
  - mem_rd and pc_enable are forced 0 in the flush cycle.
  - Flush in HOLD with instr_ready = 1: the flush wins; the instruction does not count as transferred for the bench.
- mem_rdata is only sampled in *_DATA states; its value at other times is ignored.
- Reset asserted mid-fetch: immediate return to reset values; the fetch restarts at OP_ADDR after release.
- Address wrap is owned by the program counter; the fetch stage passes pc_addr through unmodified.

Decomposition:
- Package cpu_fetch_pkg holds:
  - fetch_state_t enum for the seven states;
  - the opcode length-field position [7:6];
  - length constants LEN1 = 1, LEN2 = 2, LEN3 = 3.
- Sub-module instr_length_decode: opcode in, instr_len out, purely combinational. It is shared with the control unit.

Test Plan:
- Reset, release, RAM[0] = 8'h05, instr_ready = 1 -> pc_enable pulses once; instr_valid in cycle 2; opcode = 05, operand = 0000, instr_len = 1.
- RAM[0..2] = 8'h83, 8'h34, 8'h12 -> three pc_enable pulses; instr_valid in cycle 6; opcode = 83, operand = 1234, instr_len = 3.
- RAM[0..1] = 8'h41, 8'hAA, instr_ready held low 5 cycles -> instr_valid and outputs stable all 5 cycles; no mem_rd or pc_enable; accepted on ready; next OP_ADDR fetches address 2.
- flush asserted in LO_DATA of a 3-byte opcode, pc_addr becomes 16'h0100 -> no instr_valid for the aborted opcode; next mem_addr = 0100; pc_enable = 0 in the flush cycle.
- reset_n pulsed low asynchronously (between edges) during HI_ADDR -> outputs clear immediately; after release, mem_rd and mem_addr = pc_addr on the first edge.
- Back-to-back stream 1/2/3-byte instructions with instr_ready = 1 -> pc_enable count = 6; instructions arrive in order with correct operands.
